// File: rtl/riscv_wb_trace_tx_if.sv
// riscv_wb_trace_tx_if: byte stream from the trace framer to the UART transmitter.
interface riscv_wb_trace_tx_if;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       i_tx_ready;
  modport master (output o_tx_data, o_tx_valid, input i_tx_ready);
  modport slave (input o_tx_data, o_tx_valid, output i_tx_ready);
endinterface

// File: rtl/riscv_wb_trace_tx.sv
// riscv_wb_trace_tx: captures retired instructions into a record FIFO and streams each as a 22-byte frame.
module riscv_wb_trace_tx #(
  parameter int DEPTH = 4
) (
  input  logic                       i_riscv_mw_clk,
  input  logic                       i_riscv_mw_rst,
  input  logic                       i_trace_en,
  input  logic                       i_riscv_mw_instret_wb,
  input  logic [63:0]                i_riscv_mw_pc_wb,
  input  logic [31:0]                i_riscv_mw_inst_wb,
  input  logic [4:0]                 i_riscv_mw_rdaddr_wb,
  input  logic                       i_riscv_mw_regw_wb,
  input  logic [63:0]                i_riscv_mw_rddata_wb,
  input  logic                       i_riscv_mw_gototrap_wb,
  riscv_wb_trace_tx_if.master        tx,
  output logic                       o_full,
  output logic [7:0]                 o_drop_cnt
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = 168;
  typedef enum logic {IDLE, SEND} state_t;
  state_t        state_q;
  logic [RW-1:0] mem_q [DEPTH];
  logic [RW-1:0] shadow_q, rec_d;
  logic [AW:0]   wp_q, rp_q, cnt;
  logic [4:0]    idx_q, idx_nx;
  logic [7:0]    drop_q, data_q;
  logic          valid_q, empty, last, pop, push_req, push, drop;
  logic [175:0]  frame;
  logic [63:0]   rd_eff;
  assign rd_eff   = (i_riscv_mw_regw_wb && |i_riscv_mw_rdaddr_wb) ? i_riscv_mw_rddata_wb : 64'd0;
  assign rec_d    = {i_riscv_mw_gototrap_wb, i_riscv_mw_regw_wb, 1'b0, i_riscv_mw_rdaddr_wb,
                     rd_eff, i_riscv_mw_inst_wb, i_riscv_mw_pc_wb};
  // Byte n of the frame sits at bits [8n+:8], header first.
  assign frame    = {shadow_q, 8'hA5};
  assign cnt      = wp_q - rp_q;
  assign empty    = cnt == '0;
  assign o_full   = cnt == (AW+1)'(DEPTH);
  assign last     = state_q == SEND && tx.i_tx_ready && idx_q == 5'd21;
  assign pop      = !empty && (state_q == IDLE || last);
  assign push_req = i_trace_en && i_riscv_mw_instret_wb;
  assign push     = push_req && (!o_full || pop);
  assign drop     = push_req && o_full && !pop;
  assign idx_nx   = idx_q + 5'd1;
  assign tx.o_tx_data  = data_q;
  assign tx.o_tx_valid = valid_q;
  assign o_drop_cnt    = drop_q;
  always_ff @(posedge i_riscv_mw_clk)
    if (push) mem_q[wp_q[AW-1:0]] <= rec_d;
  always_ff @(posedge i_riscv_mw_clk or posedge i_riscv_mw_rst)
    if (i_riscv_mw_rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      idx_q    <= '0;
      drop_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      // A pop either starts a frame from IDLE or chains the next one after byte 21.
      if (pop) begin
        shadow_q <= mem_q[rp_q[AW-1:0]];
        idx_q    <= '0;
        state_q  <= SEND;
        valid_q  <= 1'b1;
        data_q   <= 8'hA5;
      end else if (state_q == SEND && tx.i_tx_ready) begin
        if (last) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          data_q  <= '0;
        end else begin
          idx_q  <= idx_nx;
          data_q <= frame[{idx_nx, 3'b000} +: 8];
        end
      end
    end
endmodule
